// File: rtl/pdt_pkg.sv
// pdt_pkg: shared constants, entry record and helpers for the gshare/MRU branch predictor
package pdt_pkg;
  localparam int XLEN = 32;
  localparam int BUS_LEN = 4;
  localparam int PDT_LEN = 8;
  localparam int PDT_ADDR = 12;
  localparam int HIST_W = 5;
  localparam int BUS_OFF = $clog2(2 * BUS_LEN);
  localparam int PDT_OFF = $clog2(PDT_LEN);
  localparam logic [1:0] CNT_RST = 2'b01;
  localparam logic [1:0] CNT_MAX = 2'b11;
  typedef struct packed {
    logic vld;
    logic [PDT_ADDR-1:0] tag;
    logic [HIST_W-1:0] hist;
  } pdt_entry_t;
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return &v ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/pdt_pht.sv
// pdt_pht: 2**HIST_W x 2-bit saturating counter table, PDT_LEN async read ports, one RMW write port
module pdt_pht
  import pdt_pkg::*;
(
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              clr,
  input  logic                              we,
  input  logic                              up,
  input  logic [HIST_W-1:0]                 waddr,
  input  logic [PDT_LEN-1:0][HIST_W-1:0]    raddr,
  output logic [PDT_LEN-1:0][1:0]           rdata
);
  logic [1:0] cnt [2**HIST_W];
  // saturating increment/decrement of one counter; clear restores weakly-not-taken
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int i = 0; i < 2**HIST_W; i++) cnt[i] <= CNT_RST;
    end else if (we) begin
      cnt[waddr] <= up ? (cnt[waddr] == CNT_MAX ? CNT_MAX : cnt[waddr] + 2'd1)
                       : (cnt[waddr] == 2'b00 ? 2'b00 : cnt[waddr] - 2'd1);
    end
  end
  for (genvar g = 0; g < PDT_LEN; g++) begin : g_rd
    assign rdata[g] = cnt[raddr[g]];
  end
endmodule

// File: rtl/predictor_gshare_lru.sv
// predictor_gshare_lru: MRU-ordered tagged local-history predictor over a shared PHT; optional stats under PDT_STAT_EN
module predictor_gshare_lru
  import pdt_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pdt_flush,
  input  logic                   imem_req,
  input  logic [XLEN-1:0]        imem_addr,
  output logic [2*BUS_LEN-1:0]   imem_predict,
  input  logic                   jcond_vld,
  input  logic [XLEN-1:0]        jcond_pc,
  input  logic                   jcond_hit,
  input  logic                   jcond_satisfied,
  output logic [31:0]            stat_update,
  output logic [31:0]            stat_miss,
  output logic [31:0]            stat_alloc
);
  pdt_entry_t [PDT_LEN-1:0] ent;
  logic [PDT_LEN-1:0][HIST_W-1:0] ridx;
  logic [PDT_LEN-1:0][1:0] rcnt;
  logic [2*BUS_LEN-1:0] mask;
  logic found;
  logic [PDT_OFF-1:0] k;
  logic act;
  logic [HIST_W-1:0] old_hist;
  pdt_entry_t new_ent;
  // parallel tag search for the resolve port and lane-mask build for the fetch port
  always_comb begin
    found = 1'b0;
    k = '0;
    mask = '0;
    for (int i = 0; i < PDT_LEN; i++) begin
      ridx[i] = ent[i].hist;
      if (ent[i].vld && XLEN'(ent[i].tag) == (jcond_pc >> 1)) begin
        found = 1'b1;
        k = PDT_OFF'(i);
      end
      if (ent[i].vld && XLEN'(ent[i].tag >> BUS_OFF) == (imem_addr >> (1 + BUS_OFF)) && rcnt[i][1])
        mask[ent[i].tag[BUS_OFF-1:0]] = 1'b1;
    end
  end
  assign act = jcond_vld && (found || !jcond_hit) && !pdt_flush;
  assign old_hist = found ? ent[k].hist : '1;
  assign new_ent = '{vld: 1'b1, tag: jcond_pc[PDT_ADDR:1], hist: {old_hist[HIST_W-2:0], jcond_satisfied}};
  pdt_pht u_pht (
    .clk   (clk),
    .rst   (rst),
    .clr   (pdt_flush),
    .we    (act),
    .up    (jcond_satisfied),
    .waddr (old_hist),
    .raddr (ridx),
    .rdata (rcnt)
  );
  // move-to-front: hit entry or fresh entry lands in slot 0, the slots above it shift up
  always_ff @(posedge clk) begin
    if (rst || pdt_flush) begin
      ent <= '0;
    end else if (act) begin
      ent[0] <= new_ent;
      for (int i = 1; i < PDT_LEN; i++) if (!found || i <= int'(k)) ent[i] <= ent[i-1];
    end
  end
  // fetch mask register, held while no lookup is requested
  always_ff @(posedge clk) begin
    if (rst || pdt_flush) imem_predict <= '0;
    else if (imem_req) imem_predict <= mask;
  end
`ifdef PDT_STAT_EN
  // saturating activity counters
  always_ff @(posedge clk) begin
    if (rst || pdt_flush) begin
      stat_update <= '0;
      stat_miss <= '0;
      stat_alloc <= '0;
    end else begin
      if (act) stat_update <= sat_inc(stat_update);
      if (jcond_vld && !jcond_hit) stat_miss <= sat_inc(stat_miss);
      if (act && !found) stat_alloc <= sat_inc(stat_alloc);
    end
  end
`else
  assign stat_update = '0;
  assign stat_miss = '0;
  assign stat_alloc = '0;
`endif
endmodule
